// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
// Scheduler for a time-multiplexed FIR tap engine: one coefficient ROM, one
// circular sample delay-line RAM and a single multiply-accumulator. For each
// accepted input sample it writes the sample into the delay line, walks TAPS
// (sample, coefficient) address pairs one per clock, and drives the MAC
// control lines delayed to match the memory read latency.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   in_strobe           new sample on the datapath write-data bus this cycle
//   samp_we             delay-line RAM write enable
//   samp_wr_addr        delay-line write address
//   samp_rd_addr        delay-line read address
//   coef_addr           coefficient ROM address
//   mac_en              MAC consumes a product this cycle
//   mac_clr             with mac_en: load instead of accumulate (first tap)
//   mac_last            with mac_en: final tap of the current result
//   out_strobe          accumulator holds a complete result (one-cycle pulse)
//   busy                a sample is being processed (WRITE through DONE)
//   overrun             one-cycle pulse, the cycle after a dropped in_strobe
//   dbg_state           current FSM state, for observation only
//
// Handshake: in_strobe is a single-cycle strobe with no backpressure. It is
// accepted only when the FSM is IDLE (busy = 0); a strobe in any other cycle,
// including DONE, is discarded and reported by overrun on the next cycle.
// All outputs are registers.
module fir_mac_sequencer #(
    parameter int TAPS       = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_strobe,
    output logic                  samp_we,
    output logic [ADDR_WIDTH-1:0] samp_wr_addr,
    output logic [ADDR_WIDTH-1:0] samp_rd_addr,
    output logic [ADDR_WIDTH-1:0] coef_addr,
    output logic                  mac_en,
    output logic                  mac_clr,
    output logic                  mac_last,
    output logic                  out_strobe,
    output logic                  busy,
    output logic                  overrun,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_TAP   = ADDR_WIDTH'(TAPS - 1);
    localparam logic [2:0]            DRAIN_LAST = 3'(RD_LATENCY - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] k;
    logic [2:0]            drain_cnt;

    // Tag issued together with each address pair; it then travels through a
    // RD_LATENCY-deep shift register so it reaches the MAC with the data.
    logic                  issue_v;
    logic                  issue_first;
    logic                  issue_last;
    logic [RD_LATENCY-1:0] pipe_v;
    logic [RD_LATENCY-1:0] pipe_first;
    logic [RD_LATENCY-1:0] pipe_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            k            <= '0;
            drain_cnt    <= '0;
            samp_we      <= 1'b0;
            samp_wr_addr <= '0;
            samp_rd_addr <= '0;
            coef_addr    <= '0;
            out_strobe   <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            issue_v      <= 1'b0;
            issue_first  <= 1'b0;
            issue_last   <= 1'b0;
            pipe_v       <= '0;
            pipe_first   <= '0;
            pipe_last    <= '0;
        end else begin
            // Any strobe outside IDLE is a drop; it never touches the FSM.
            overrun <= in_strobe && (state != IDLE);

            pipe_v[0]     <= issue_v;
            pipe_first[0] <= issue_first;
            pipe_last[0]  <= issue_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_v[i]     <= pipe_v[i-1];
                pipe_first[i] <= pipe_first[i-1];
                pipe_last[i]  <= pipe_last[i-1];
            end

            case (state)
                IDLE: begin
                    if (in_strobe) begin
                        state        <= WRITE;
                        samp_we      <= 1'b1;
                        samp_wr_addr <= wr_ptr;
                        busy         <= 1'b1;
                    end
                end
                WRITE: begin
                    // The sample was written this cycle, so the k = 0 read
                    // of the same location issued next cycle sees it.
                    state        <= RUN;
                    samp_we      <= 1'b0;
                    k            <= '0;
                    coef_addr    <= '0;
                    samp_rd_addr <= wr_ptr;
                    issue_v      <= 1'b1;
                    issue_first  <= 1'b1;
                    issue_last   <= 1'b0;
                end
                RUN: begin
                    if (k == LAST_TAP) begin
                        state       <= DRAIN;
                        drain_cnt   <= '0;
                        issue_v     <= 1'b0;
                        issue_first <= 1'b0;
                        issue_last  <= 1'b0;
                    end else begin
                        k           <= k + 1'b1;
                        coef_addr   <= k + 1'b1;
                        // Explicit wrap keeps addresses inside 0..TAPS-1 for
                        // tap counts that are not a power of two.
                        samp_rd_addr <= (samp_rd_addr == '0) ? LAST_TAP
                                                             : samp_rd_addr - 1'b1;
                        issue_v     <= 1'b1;
                        issue_first <= 1'b0;
                        issue_last  <= ((k + 1'b1) == LAST_TAP);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state      <= DONE;
                        out_strobe <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    out_strobe <= 1'b0;
                    busy       <= 1'b0;
                    wr_ptr     <= (wr_ptr == LAST_TAP) ? '0 : wr_ptr + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mac_en    = pipe_v[RD_LATENCY-1];
    assign mac_clr   = pipe_first[RD_LATENCY-1];
    assign mac_last  = pipe_last[RD_LATENCY-1];
    assign dbg_state = state;

endmodule
